// File: rtl/cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// cmd_arbiter_if
// Bundles every signal between the command arbiter, its command sources and
// the single command consumer (cmd_proc).
//
//   src_cmd      sources -> arb   NUM_SRC*CMD_W  per-source command words
//   src_rdy      sources -> arb   NUM_SRC        per-source command pending
//   src_clr      arb -> sources   NUM_SRC        granted command consumed
//   src_resp_vld arb -> sources   NUM_SRC        response valid for source i
//   src_resp     arb -> sources   RESP_W         shared response bus
//   cmd          arb -> cmd_proc  CMD_W          latched command
//   cmd_rdy      arb -> cmd_proc  1              command valid
//   clr_cmd_rdy  cmd_proc -> arb  1              command consumed
//   send_resp    cmd_proc -> arb  1              response strobe
//   resp         cmd_proc -> arb  RESP_W         response value
//   owner        arb -> observer  OWN_W          granted source index
//   busy         arb -> observer  1              transaction in progress
//   tmo          arb -> observer  1              watchdog expiry pulse
//
// slave  : the arbiter side.
// master : the side that drives sources/cmd_proc and observes the arbiter.
// ---------------------------------------------------------------------------
interface cmd_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int CMD_W   = 16,
  parameter int RESP_W  = 8
);
  localparam int OWN_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC*CMD_W-1:0] src_cmd;
  logic [NUM_SRC-1:0]       src_rdy;
  logic [NUM_SRC-1:0]       src_clr;
  logic [NUM_SRC-1:0]       src_resp_vld;
  logic [RESP_W-1:0]        src_resp;
  logic [CMD_W-1:0]         cmd;
  logic                     cmd_rdy;
  logic                     clr_cmd_rdy;
  logic                     send_resp;
  logic [RESP_W-1:0]        resp;
  logic [OWN_W-1:0]         owner;
  logic                     busy;
  logic                     tmo;

  modport slave (
    input  src_cmd, src_rdy, clr_cmd_rdy, send_resp, resp,
    output src_clr, src_resp_vld, src_resp, cmd, cmd_rdy, owner, busy, tmo
  );

  modport master (
    output src_cmd, src_rdy, clr_cmd_rdy, send_resp, resp,
    input  src_clr, src_resp_vld, src_resp, cmd, cmd_rdy, owner, busy, tmo
  );
endinterface

// File: rtl/cmd_arbiter.sv
// ---------------------------------------------------------------------------
// cmd_arbiter
// Grants one of NUM_SRC command sources at a time, latches its command for
// cmd_proc with a cmd_rdy/clr_cmd_rdy handshake, and routes cmd_proc's
// response back to the granted source only. Arbitration is fixed priority
// (lowest index) or round-robin. An optional watchdog releases a hung
// transaction and answers the owner with TMO_RESP.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   bus    cmd_arbiter_if.slave  source, cmd_proc and status signals
//
// Every output is driven straight from a flop.
// ---------------------------------------------------------------------------
module cmd_arbiter #(
  parameter int                NUM_SRC  = 2,
  parameter int                CMD_W    = 16,
  parameter int                RESP_W   = 8,
  parameter int                RR       = 0,
  parameter int                TMO_CYC  = 0,
  parameter logic [RESP_W-1:0] TMO_RESP = RESP_W'(8'hEE)
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_arbiter_if.slave       bus
);

  localparam int OWN_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // Counter must reach TMO_CYC: a consume in the expiry cycle moves to EXEC
  // with one more increment, and that EXEC cycle then expires immediately.
  localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RESP_W-1:0]   src_resp_q, src_resp_d;
  logic [NUM_SRC-1:0]  src_clr_q, src_clr_d;
  logic [NUM_SRC-1:0]  src_resp_vld_q, src_resp_vld_d;
  logic                cmd_rdy_q, cmd_rdy_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;

  logic                win_vld;
  logic [OWN_W-1:0]    win_idx;
  logic [OWN_W-1:0]    win_nxt;
  logic [CMD_W-1:0]    win_cmd;
  logic [NUM_SRC-1:0]  own_oh;
  logic                expire;

  // One-hot of the granted source, used to steer clr/response pulses.
  assign own_oh = NUM_SRC'(1) << owner_q;

  // Watchdog fires on the cycle the count reaches TMO_CYC-1 (or beyond, which
  // only happens after a consume landed exactly in the expiry cycle).
  assign expire = (TMO_CYC > 0) && (int'(cnt_q) >= TMO_CYC - 1);

  // Winner selection: every pending source gets its distance from the
  // search start (wrapping modulo NUM_SRC); the smallest distance wins.
  // Fixed priority simply searches from index 0.
  always_comb begin : arb
    int start;
    int off;
    int best;
    start   = (RR != 0) ? int'(rr_ptr_q) : 0;
    off     = 0;
    best    = NUM_SRC;
    win_vld = 1'b0;
    win_idx = '0;
    win_nxt = '0;
    win_cmd = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      off = (j >= start) ? (j - start) : (j + NUM_SRC - start);
      if (bus.src_rdy[j] && (off < best)) begin
        best    = off;
        win_vld = 1'b1;
        win_idx = OWN_W'(j);
        win_nxt = (j == NUM_SRC - 1) ? '0 : OWN_W'(j + 1);
        win_cmd = bus.src_cmd[j*CMD_W +: CMD_W];
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    src_resp_d     = src_resp_q;
    src_clr_d      = '0;
    src_resp_vld_d = '0;
    tmo_d          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = GRANT;
          cmd_d    = win_cmd;
          owner_d  = win_idx;
          rr_ptr_d = win_nxt;
          cnt_d    = '0;
        end
      end

      GRANT: begin
        if (bus.clr_cmd_rdy) begin
          src_clr_d = own_oh;
          if (bus.send_resp) begin
            // Consume and respond in one cycle: finish the transaction now.
            src_resp_d     = bus.resp;
            src_resp_vld_d = own_oh;
            state_d        = IDLE;
          end else begin
            state_d = EXEC;
            if (TMO_CYC > 0) cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (expire) begin
          tmo_d          = 1'b1;
          src_resp_d     = TMO_RESP;
          src_resp_vld_d = own_oh;
          src_clr_d      = own_oh;
          state_d        = IDLE;
        end else if (TMO_CYC > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EXEC: begin
        if (bus.send_resp) begin
          src_resp_d     = bus.resp;
          src_resp_vld_d = own_oh;
          state_d        = IDLE;
        end else if (expire) begin
          tmo_d          = 1'b1;
          src_resp_d     = TMO_RESP;
          src_resp_vld_d = own_oh;
          state_d        = IDLE;
        end else if (TMO_CYC > 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_rdy_d = (state_d == GRANT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= '0;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      src_resp_q     <= '0;
      src_clr_q      <= '0;
      src_resp_vld_q <= '0;
      cmd_rdy_q      <= 1'b0;
      busy_q         <= 1'b0;
      tmo_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      src_resp_q     <= src_resp_d;
      src_clr_q      <= src_clr_d;
      src_resp_vld_q <= src_resp_vld_d;
      cmd_rdy_q      <= cmd_rdy_d;
      busy_q         <= busy_d;
      tmo_q          <= tmo_d;
    end
  end

  assign bus.cmd          = cmd_q;
  assign bus.owner        = owner_q;
  assign bus.cmd_rdy      = cmd_rdy_q;
  assign bus.busy         = busy_q;
  assign bus.tmo          = tmo_q;
  assign bus.src_resp     = src_resp_q;
  assign bus.src_clr      = src_clr_q;
  assign bus.src_resp_vld = src_resp_vld_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmd_arbiter
// Two arbiter instances share clock and reset:
//   u_fp : NUM_SRC=2, fixed priority, watchdog TMO_CYC=16
//   u_rr : NUM_SRC=4, round-robin, watchdog disabled
// Directed steps with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_cmd_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  cmd_arbiter_if #(.NUM_SRC(2), .CMD_W(16), .RESP_W(8)) if0 ();
  cmd_arbiter_if #(.NUM_SRC(4), .CMD_W(16), .RESP_W(8)) if1 ();

  cmd_arbiter #(
    .NUM_SRC(2), .CMD_W(16), .RESP_W(8), .RR(0), .TMO_CYC(16), .TMO_RESP(8'hEE)
  ) u_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  cmd_arbiter #(
    .NUM_SRC(4), .CMD_W(16), .RESP_W(8), .RR(1), .TMO_CYC(0), .TMO_RESP(8'hEE)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    if0.src_cmd = '0; if0.src_rdy = '0; if0.clr_cmd_rdy = 1'b0;
    if0.send_resp = 1'b0; if0.resp = '0;
    if1.src_cmd = '0; if1.src_rdy = '0; if1.clr_cmd_rdy = 1'b0;
    if1.send_resp = 1'b0; if1.resp = '0;

    // ---- reset state ----
    step(3);
    chk("rst_cmd",      if0.cmd,          0);
    chk("rst_cmd_rdy",  if0.cmd_rdy,      0);
    chk("rst_owner",    if0.owner,        0);
    chk("rst_busy",     if0.busy,         0);
    chk("rst_tmo",      if0.tmo,          0);
    chk("rst_src_resp", if0.src_resp,     0);
    chk("rst_src_clr",  if0.src_clr,      0);
    chk("rst_resp_vld", if0.src_resp_vld, 0);
    rst_n = 1'b1;
    step(1);
    chk("idle_busy", if0.busy, 0);

    // ---- fixed priority: both pending, source 0 wins ----
    if0.src_cmd = {16'h4001, 16'h2000};
    if0.src_rdy = 2'b11;
    step(1);
    chk("fp_cmd",     if0.cmd,     16'h2000);
    chk("fp_owner",   if0.owner,   0);
    chk("fp_cmd_rdy", if0.cmd_rdy, 1);
    chk("fp_busy",    if0.busy,    1);
    if0.clr_cmd_rdy = 1'b1;
    step(1);
    chk("fp_src_clr",    if0.src_clr, 2'b01);
    chk("fp_cmd_rdy_lo", if0.cmd_rdy, 0);
    chk("fp_busy_exec",  if0.busy,    1);
    if0.clr_cmd_rdy = 1'b0;
    if0.src_rdy = 2'b10;
    step(1);
    chk("fp_src_clr_1cyc", if0.src_clr,      2'b00);
    chk("fp_no_vld_yet",   if0.src_resp_vld, 2'b00);
    if0.send_resp = 1'b1;
    if0.resp = 8'hA5;
    step(1);
    chk("fp_resp_vld",  if0.src_resp_vld, 2'b01);
    chk("fp_src_resp",  if0.src_resp,     8'hA5);
    chk("fp_busy_idle", if0.busy,         0);
    if0.send_resp = 1'b0;
    if0.resp = 8'h00;
    step(1);
    chk("fp_vld_1cyc",  if0.src_resp_vld, 2'b00);
    chk("fp_resp_hold", if0.src_resp,     8'hA5);
    chk("fp_owner1",    if0.owner,        1);
    chk("fp_cmd1",      if0.cmd,          16'h4001);
    chk("fp_cmd_rdy1",  if0.cmd_rdy,      1);

    // ---- consume and respond in the same GRANT cycle ----
    if0.clr_cmd_rdy = 1'b1;
    if0.send_resp = 1'b1;
    if0.resp = 8'h5A;
    step(1);
    chk("both_src_clr",  if0.src_clr,      2'b10);
    chk("both_resp_vld", if0.src_resp_vld, 2'b10);
    chk("both_src_resp", if0.src_resp,     8'h5A);
    chk("both_busy",     if0.busy,         0);
    if0.clr_cmd_rdy = 1'b0;
    if0.send_resp = 1'b0;
    if0.src_rdy = 2'b00;
    step(1);
    chk("both_clr_1cyc", if0.src_clr,      2'b00);
    chk("both_vld_1cyc", if0.src_resp_vld, 2'b00);

    // ---- watchdog expiry while still in GRANT ----
    if0.src_cmd = {16'h0000, 16'h5555};
    if0.src_rdy = 2'b01;
    step(1);
    chk("tg_cmd_rdy", if0.cmd_rdy, 1);
    step(15);
    chk("tg_no_tmo_15", if0.tmo,     0);
    chk("tg_rdy_15",    if0.cmd_rdy, 1);
    step(1);
    chk("tg_tmo",      if0.tmo,          1);
    chk("tg_src_resp", if0.src_resp,     8'hEE);
    chk("tg_resp_vld", if0.src_resp_vld, 2'b01);
    chk("tg_src_clr",  if0.src_clr,      2'b01);
    chk("tg_cmd_rdy0", if0.cmd_rdy,      0);
    chk("tg_busy",     if0.busy,         0);
    if0.src_rdy = 2'b00;
    step(1);
    chk("tg_tmo_1cyc", if0.tmo, 0);

    // ---- ignored events: send_resp in GRANT, input changes in EXEC, IDLE strobes ----
    if0.src_cmd = {16'h0000, 16'h1111};
    if0.src_rdy = 2'b01;
    step(1);
    chk("ig_cmd", if0.cmd, 16'h1111);
    if0.send_resp = 1'b1;
    if0.resp = 8'h77;
    step(1);
    chk("ig_grant_send_vld", if0.src_resp_vld, 2'b00);
    chk("ig_grant_send_rdy", if0.cmd_rdy,      1);
    if0.send_resp = 1'b0;
    if0.clr_cmd_rdy = 1'b1;
    step(1);
    chk("ig_clr", if0.src_clr, 2'b01);
    if0.clr_cmd_rdy = 1'b0;
    if0.src_cmd = {16'hABCD, 16'hBEEF};
    if0.src_rdy = 2'b10;
    step(1);
    chk("ig_cmd_hold",   if0.cmd,   16'h1111);
    chk("ig_owner_hold", if0.owner, 0);
    if0.send_resp = 1'b1;
    if0.resp = 8'hC3;
    if0.src_rdy = 2'b00;
    step(1);
    chk("ig_resp_vld",  if0.src_resp_vld, 2'b01);
    chk("ig_src_resp",  if0.src_resp,     8'hC3);
    if0.resp = 8'h99;
    if0.clr_cmd_rdy = 1'b1;
    step(1);
    chk("ig_idle_vld",  if0.src_resp_vld, 2'b00);
    chk("ig_idle_clr",  if0.src_clr,      2'b00);
    chk("ig_idle_resp", if0.src_resp,     8'hC3);
    chk("ig_idle_busy", if0.busy,         0);
    if0.send_resp = 1'b0;
    if0.clr_cmd_rdy = 1'b0;

    // ---- watchdog expiry in EXEC ----
    if0.src_cmd = {16'h0000, 16'h1234};
    if0.src_rdy = 2'b01;
    step(1);
    chk("te_cmd_rdy", if0.cmd_rdy, 1);
    if0.clr_cmd_rdy = 1'b1;
    step(1);
    if0.clr_cmd_rdy = 1'b0;
    if0.src_rdy = 2'b00;
    step(14);
    chk("te_no_tmo_15", if0.tmo,  0);
    chk("te_busy_15",   if0.busy, 1);
    step(1);
    chk("te_tmo",      if0.tmo,          1);
    chk("te_src_resp", if0.src_resp,     8'hEE);
    chk("te_resp_vld", if0.src_resp_vld, 2'b01);
    chk("te_src_clr",  if0.src_clr,      2'b00);
    chk("te_busy",     if0.busy,         0);
    step(1);
    chk("te_tmo_1cyc", if0.tmo,          0);
    chk("te_vld_1cyc", if0.src_resp_vld, 2'b00);

    // ---- round-robin over four always-pending sources ----
    if1.src_cmd = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    if1.src_rdy = 4'hF;
    for (int t = 0; t < 8; t++) begin
      step(1);
      chk("rr_owner",   if1.owner,   t % 4);
      chk("rr_cmd",     if1.cmd,     16'h0100 + t % 4);
      chk("rr_cmd_rdy", if1.cmd_rdy, 1);
      if1.clr_cmd_rdy = 1'b1;
      if1.send_resp = 1'b1;
      if1.resp = 8'(8'h30 + t);
      step(1);
      chk("rr_resp_vld", if1.src_resp_vld, 32'(1) << (t % 4));
      chk("rr_src_clr",  if1.src_clr,      32'(1) << (t % 4));
      if1.clr_cmd_rdy = 1'b0;
      if1.send_resp = 1'b0;
    end

    // ---- async reset in EXEC ----
    if1.src_rdy = 4'b0110;
    step(1);
    chk("ar_owner_pre", if1.owner, 1);
    if1.clr_cmd_rdy = 1'b1;
    step(1);
    if1.clr_cmd_rdy = 1'b0;
    chk("ar_busy_exec", if1.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_cmd",      if1.cmd,          0);
    chk("ar_owner",    if1.owner,        0);
    chk("ar_busy",     if1.busy,         0);
    chk("ar_cmd_rdy",  if1.cmd_rdy,      0);
    chk("ar_src_resp", if1.src_resp,     0);
    chk("ar_fp_resp",  if0.src_resp,     0);
    if1.send_resp = 1'b1;
    if1.resp = 8'h66;
    step(1);
    rst_n = 1'b1;
    if1.send_resp = 1'b0;
    step(1);
    chk("ar_no_vld",     if1.src_resp_vld, 0);
    chk("ar_regrant",    if1.owner,        1);
    chk("ar_regrant_cmd", if1.cmd,         16'h0101);
    chk("ar_cmd_rdy1",   if1.cmd_rdy,      1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
